// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and address-fault helper for mem_responder
package mem_pkg;

   localparam int WORD_W        = 32;
   localparam int ADDR_W        = 32;
   localparam int DEFAULT_DEPTH = 64;
   localparam int CTR_W         = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Misaligned byte address or word index beyond the end of memory
   function automatic logic addr_fault(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] depth);
      return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_W-1:2]} >= depth);
   endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - loadable wait-state down-counter with expire flag (count == 1)
module mem_wait_ctr
   import mem_pkg::*;
#(
   parameter int W = CTR_W
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_expire
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multicycle CPU memory responder; MEM_RESPONDER_WAIT_EN enables wait states
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WAIT  = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              ack,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t              r_state;
   logic [WORD_W-1:0]   r_mem [DEPTH];

   logic                w_accept;
   logic                w_do_access;
   logic                w_acc_we;
   logic [ADDR_W-1:0]   w_acc_addr;
   logic [WORD_W-1:0]   w_acc_wdata;
   logic [IDX_W-1:0]    w_idx;
   logic                w_fault;
   logic                w_mem_we;

   assign w_accept = (r_state == IDLE) && req;

`ifdef MEM_RESPONDER_WAIT_EN
   localparam logic W_GO_DIRECT = (WAIT == 0);

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [WORD_W-1:0]   r_wdata;
   logic                w_expire;
   logic                w_busy_done;

   mem_wait_ctr #(.W(CTR_W)) u_wait_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_load_val (CTR_W'(WAIT)),
      .i_dec      (r_state == BUSY),
      .o_expire   (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_we    <= we;
         r_addr  <= addr;
         r_wdata <= wdata;
      end
   end

   assign w_busy_done = (r_state == BUSY) && w_expire;
   // Direct IDLE->DONE path (WAIT=0) uses the live inputs; BUSY uses the latched copies
   assign w_acc_we    = (r_state == IDLE) ? we    : r_we;
   assign w_acc_addr  = (r_state == IDLE) ? addr  : r_addr;
   assign w_acc_wdata = (r_state == IDLE) ? wdata : r_wdata;
   assign w_do_access = rst_n && ((w_accept && W_GO_DIRECT) || w_busy_done);
`else
   logic [CTR_W-1:0]    w_unused_wait;

   assign w_unused_wait = CTR_W'(WAIT);
   assign w_acc_we      = we;
   assign w_acc_addr    = addr;
   assign w_acc_wdata   = wdata;
   assign w_do_access   = rst_n && w_accept;
`endif

   assign w_idx    = w_acc_addr[IDX_W+1:2];
   assign w_fault  = addr_fault(w_acc_addr, ADDR_W'(DEPTH));
   assign w_mem_we = w_do_access && w_acc_we && !w_fault;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= w_acc_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         ack     <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
      end else begin
         ack <= w_do_access;
         err <= w_do_access && w_fault;
         if (w_do_access && !w_acc_we) begin
            rdata <= w_fault ? '0 : r_mem[w_idx];
         end
         case (r_state)
`ifdef MEM_RESPONDER_WAIT_EN
            IDLE:    if (req) r_state <= W_GO_DIRECT ? DONE : BUSY;
            BUSY:    if (w_busy_done) r_state <= DONE;
`else
            IDLE:    if (req) r_state <= DONE;
`endif
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
